// File: rtl/jtag_dma_engine_pkg.sv
// Shared state encoding, buffer depth and bus field widths for the JTAG chain-1 DMA engine.
package jtag_dma_engine_pkg;

    localparam int BUF_WORDS   = 256;
    localparam int BUS_DATA_W  = 32;
    localparam int BUS_BE_W    = 4;
    localparam int BUS_BURST_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_INIT    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_READ    = 3'd4,
        ST_END     = 3'd5
    } dma_state_e;

    // Received word count clipped to the 8-bit block-size register.
    function automatic logic [7:0] sat_count(input logic [8:0] count);
        if (count[8]) begin
            return 8'hFF;
        end else begin
            return count[7:0];
        end
    endfunction

endpackage

// File: rtl/jtag_dma_engine_bus_master_if.sv
// Bus request/grant handshake and INIT-cycle field drive, shareable by any bus master FSM.
module dma_bus_master_if
    import jtag_dma_engine_pkg::*;
(
    input  dma_state_e             state_i,
    input  logic                   bus_grant_i,
    input  logic                   bus_error_i,
    input  logic [BUS_DATA_W-1:0]  addr_i,
    input  logic                   read_i,
    input  logic [BUS_BE_W-1:0]    be_i,
    input  logic [BUS_BURST_W-1:0] burst_i,
    output logic                   bus_request_o,
    output logic                   granted_o,
    output logic                   begin_transaction_o,
    output logic [BUS_DATA_W-1:0]  init_addr_o,
    output logic                   read_n_write_o,
    output logic [BUS_BE_W-1:0]    byte_enables_o,
    output logic [BUS_BURST_W-1:0] burst_size_o
);

    // Request until granted, then present the transaction header for one cycle.
    always_comb begin
        bus_request_o       = 1'b0;
        granted_o           = 1'b0;
        begin_transaction_o = 1'b0;
        init_addr_o         = '0;
        read_n_write_o      = 1'b0;
        byte_enables_o      = '0;
        burst_size_o        = '0;
        if (state_i == ST_REQUEST) begin
            bus_request_o = 1'b1;
            granted_o     = bus_grant_i & ~bus_error_i;
        end else if (state_i == ST_INIT) begin
            begin_transaction_o = 1'b1;
            init_addr_o         = addr_i;
            read_n_write_o      = read_i;
            byte_enables_o      = be_i;
            burst_size_o        = burst_i;
        end else begin
            bus_request_o = 1'b0;
        end
    end

endmodule

// File: rtl/jtag_dma_engine.sv
// Single-burst bus-master DMA between the DMA bank of the JTAG ping-pong buffer and the system bus.
module jtag_dma_engine #(
    parameter int ADDR_W    = 9,
    parameter int BUF_WORDS = jtag_dma_engine_pkg::BUF_WORDS
) (
    input  logic              system_clk,
    input  logic              n_reset,
    input  logic              launch_write,
    input  logic              launch_read,
    input  logic [31:0]       dma_address,
    input  logic [3:0]        dma_byte_enable,
    input  logic [7:0]        dma_burst_size,
    output logic              dma_busy,
    output logic [7:0]        dma_block_size,
    output logic              dma_error,
    output logic [ADDR_W-1:0] pp_address,
    output logic              pp_write_enable,
    output logic [31:0]       pp_data_in,
    input  logic [31:0]       pp_data_out,
    output logic              bus_request,
    input  logic              bus_grant,
    output logic              begin_transaction,
    output logic [31:0]       address_data_out,
    output logic              read_n_write,
    output logic [3:0]        byte_enables,
    output logic [7:0]        burst_size,
    output logic              data_valid_out,
    output logic              end_transaction_out,
    input  logic [31:0]       address_data_in,
    input  logic              data_valid_in,
    input  logic              end_transaction_in,
    input  logic              busy_in,
    input  logic              bus_error_in
);
    import jtag_dma_engine_pkg::*;

    dma_state_e             state_q, state_d;
    logic [BUS_DATA_W-1:0]  addr_q, addr_d;
    logic [BUS_BE_W-1:0]    be_q, be_d;
    logic [BUS_BURST_W-1:0] burst_q, burst_d;
    logic                   read_q, read_d;
    logic [8:0]             beat_q, beat_d;
    logic [7:0]             block_q, block_d;
    logic                   error_q, error_d;

    logic                   granted_s;
    logic [7:0]             buf_index_s;
    logic [BUS_DATA_W-1:0]  init_addr_s;
    logic [BUS_DATA_W-1:0]  wr_data_s;

    dma_bus_master_if u_bus_if (
        .state_i             (state_q),
        .bus_grant_i         (bus_grant),
        .bus_error_i         (bus_error_in),
        .addr_i              (addr_q),
        .read_i              (read_q),
        .be_i                (be_q),
        .burst_i             (burst_q),
        .bus_request_o       (bus_request),
        .granted_o           (granted_s),
        .begin_transaction_o (begin_transaction),
        .init_addr_o         (init_addr_s),
        .read_n_write_o      (read_n_write),
        .byte_enables_o      (byte_enables),
        .burst_size_o        (burst_size)
    );

    // Next-state, beat counting and buffer/bus datapath steering.
    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        be_d                = be_q;
        burst_d             = burst_q;
        read_d              = read_q;
        beat_d              = beat_q;
        block_d             = block_q;
        error_d             = error_q;
        buf_index_s         = beat_q[7:0];
        wr_data_s           = '0;
        pp_write_enable     = 1'b0;
        pp_data_in          = '0;
        data_valid_out      = 1'b0;
        end_transaction_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch_read || launch_write) begin
                    read_d  = launch_read;
                    addr_d  = dma_address;
                    be_d    = dma_byte_enable;
                    burst_d = dma_burst_size;
                    beat_d  = 9'd0;
                    error_d = 1'b0;
                    state_d = ST_REQUEST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (bus_error_in) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (granted_s) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_REQUEST;
                end
            end
            ST_INIT: begin
                if (bus_error_in) begin
                    error_d = 1'b1;
                    state_d = ST_END;
                end else begin
                    state_d = read_q ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Look one word ahead on acceptance so the RAM output tracks the current beat.
                data_valid_out = 1'b1;
                wr_data_s      = pp_data_out;
                if (bus_error_in) begin
                    error_d = 1'b1;
                    state_d = ST_END;
                end else if (!busy_in) begin
                    buf_index_s = beat_q[7:0] + 8'd1;
                    if (beat_q == {1'b0, burst_q}) begin
                        state_d = ST_END;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (bus_error_in) begin
                    error_d = 1'b1;
                    state_d = ST_END;
                end else begin
                    if (data_valid_in && (beat_q < 9'(BUF_WORDS))) begin
                        pp_write_enable = 1'b1;
                        pp_data_in      = address_data_in;
                        beat_d          = beat_q + 9'd1;
                    end else begin
                        beat_d = beat_q;
                    end
                    if (end_transaction_in) begin
                        block_d = sat_count(beat_d);
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_END: begin
                end_transaction_out = 1'b1;
                if (bus_error_in) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine registers; reset overrides any burst in flight.
    always_ff @(posedge system_clk) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            burst_q <= '0;
            read_q  <= 1'b0;
            beat_q  <= 9'd0;
            block_q <= 8'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            burst_q <= burst_d;
            read_q  <= read_d;
            beat_q  <= beat_d;
            block_q <= block_d;
            error_q <= error_d;
        end
    end

    assign pp_address       = {{(ADDR_W-8){1'b0}}, buf_index_s};
    assign address_data_out = init_addr_s | wr_data_s;
    assign dma_busy         = (state_q != ST_IDLE);
    assign dma_block_size   = block_q;
    assign dma_error        = error_q;

endmodule

// File: tb/tb_jtag_dma_engine.sv
// Randomised scoreboard bench for jtag_dma_engine: stimulus tasks queue expectations, a negedge monitor consumes them.
`timescale 1ns/1ps
module tb_jtag_dma_engine;

    logic        system_clk, n_reset;
    logic        launch_write, launch_read;
    logic [31:0] dma_address;
    logic [3:0]  dma_byte_enable;
    logic [7:0]  dma_burst_size;
    logic        dma_busy, dma_error;
    logic [7:0]  dma_block_size;
    logic [8:0]  pp_address;
    logic        pp_write_enable;
    logic [31:0] pp_data_in, pp_data_out;
    logic        bus_request, bus_grant, begin_transaction;
    logic [31:0] address_data_out, address_data_in;
    logic        read_n_write;
    logic [3:0]  byte_enables;
    logic [7:0]  burst_size;
    logic        data_valid_out, end_transaction_out;
    logic        data_valid_in, end_transaction_in, busy_in, bus_error_in;

    typedef struct { logic [31:0] addr; logic rnw; logic [3:0] be; logic [7:0] burst; int req_len; } init_t;
    typedef struct { logic [8:0] addr; logic [31:0] data; } ramw_t;
    typedef struct { int len; logic [7:0] blk; logic err; } done_t;

    init_t       init_q[$];
    logic [31:0] beat_q[$];
    ramw_t       ramw_q[$];
    done_t       done_q[$];
    int          end_expect = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  model_block = 8'd0;
    logic [31:0] src_mem [0:511];

    jtag_dma_engine dut (
        .system_clk(system_clk), .n_reset(n_reset),
        .launch_write(launch_write), .launch_read(launch_read),
        .dma_address(dma_address), .dma_byte_enable(dma_byte_enable), .dma_burst_size(dma_burst_size),
        .dma_busy(dma_busy), .dma_block_size(dma_block_size), .dma_error(dma_error),
        .pp_address(pp_address), .pp_write_enable(pp_write_enable),
        .pp_data_in(pp_data_in), .pp_data_out(pp_data_out),
        .bus_request(bus_request), .bus_grant(bus_grant), .begin_transaction(begin_transaction),
        .address_data_out(address_data_out), .read_n_write(read_n_write),
        .byte_enables(byte_enables), .burst_size(burst_size),
        .data_valid_out(data_valid_out), .end_transaction_out(end_transaction_out),
        .address_data_in(address_data_in), .data_valid_in(data_valid_in),
        .end_transaction_in(end_transaction_in), .busy_in(busy_in), .bus_error_in(bus_error_in)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    // Buffer read port: one-cycle synchronous latency from bench-owned contents.
    always @(posedge system_clk) pp_data_out <= src_mem[pp_address];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({dma_busy, dma_block_size, dma_error, pp_address, pp_write_enable, pp_data_in,
                     bus_request, begin_transaction, address_data_out, read_n_write, byte_enables,
                     burst_size, data_valid_out, end_transaction_out});
    endfunction

    // Monitor: consume expectations whenever the DUT presents a transaction event.
    int    busy_len, req_cnt, wcnt;
    logic  prev_busy;
    init_t m_ie;
    ramw_t m_rw;
    done_t m_de;
    always @(negedge system_clk) begin
        if (!n_reset) begin
            busy_len = 0; req_cnt = 0; wcnt = 0; prev_busy = 1'b0;
        end else begin
            if (bus_request) req_cnt++;
            if (begin_transaction) begin
                if (init_q.size() == 0) chk("init_unexpected", 128'(begin_transaction), 128'd0);
                else begin
                    m_ie = init_q.pop_front();
                    chk("init_addr", 128'(address_data_out), 128'(m_ie.addr));
                    chk("init_rnw", 128'(read_n_write), 128'(m_ie.rnw));
                    chk("init_be", 128'(byte_enables), 128'(m_ie.be));
                    chk("init_burst", 128'(burst_size), 128'(m_ie.burst));
                    chk("request_cycles", 128'(req_cnt), 128'(m_ie.req_len));
                end
                req_cnt = 0; wcnt = 0;
            end
            if (data_valid_out && !bus_error_in) begin
                if (beat_q.size() == 0) chk("beat_unexpected", 128'(data_valid_out), 128'd0);
                else if (busy_in) begin
                    chk("stall_data", 128'(address_data_out), 128'(beat_q[0]));
                    chk("stall_pp_addr", 128'(pp_address), 128'(wcnt));
                end else begin
                    chk("beat_data", 128'(address_data_out), 128'(beat_q.pop_front()));
                    chk("beat_pp_addr", 128'(pp_address), 128'((wcnt + 1) % 256));
                    wcnt++;
                end
            end
            if (pp_write_enable) begin
                if (ramw_q.size() == 0) chk("bufwr_unexpected", 128'(pp_write_enable), 128'd0);
                else begin
                    m_rw = ramw_q.pop_front();
                    chk("bufwr_addr", 128'(pp_address), 128'(m_rw.addr));
                    chk("bufwr_data", 128'(pp_data_in), 128'(m_rw.data));
                end
            end
            if (end_transaction_out) begin
                if (end_expect == 0) chk("end_unexpected", 128'(end_transaction_out), 128'd0);
                else begin
                    end_expect--;
                    chk("end_busy", 128'(dma_busy), 128'd1);
                end
            end
            if (dma_busy) busy_len++;
            else if (prev_busy) begin
                if (done_q.size() == 0) chk("done_unexpected", 128'(prev_busy), 128'd0);
                else begin
                    m_de = done_q.pop_front();
                    chk("busy_cycles", 128'(busy_len), 128'(m_de.len));
                    chk("block_size", 128'(dma_block_size), 128'(m_de.blk));
                    chk("dma_error", 128'(dma_error), 128'(m_de.err));
                end
                busy_len = 0;
            end
            prev_busy = dma_busy;
        end
    end

    task automatic step();
        @(posedge system_clk);
        #1;
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        launch_write = 1'b0; launch_read = 1'b0; bus_grant = 1'b0;
        data_valid_in = 1'b0; end_transaction_in = 1'b0; busy_in = 1'b0; bus_error_in = 1'b0;
        init_q.delete(); beat_q.delete(); ramw_q.delete(); done_q.delete();
        end_expect = 0;
        model_block = 8'd0;
        step(); step();
        @(negedge system_clk);
        chk("reset_outputs", all_outs(), 128'd0);
        @(posedge system_clk);
        #1;
        n_reset = 1'b1;
        step();
    endtask

    // Write burst of n+1 beats: grant after g cycles, optional stalls, optional error at err_beat.
    task automatic do_write(input logic [31:0] addr, input int n, input int g,
                            input int stall_beat, input int stall_len, input bit rand_stall,
                            input int err_beat, input bit stray_read);
        int st[256];
        int nb, len;
        init_t ie;
        done_t de;
        nb  = (err_beat >= 0) ? err_beat : n + 1;
        len = g + 3 + ((err_beat >= 0) ? 1 : 0);
        for (int k = 0; k <= n; k++) src_mem[k] = $urandom;
        for (int k = 0; k < nb; k++) begin
            st[k] = (k == stall_beat) ? stall_len : 0;
            if (rand_stall && ($urandom_range(0, 3) == 0)) st[k] = int'($urandom_range(1, 3));
            len += st[k] + 1;
            beat_q.push_back(src_mem[k]);
        end
        ie.addr = addr; ie.rnw = 1'b0; ie.be = 4'($urandom); ie.burst = 8'(n); ie.req_len = g + 1;
        init_q.push_back(ie);
        de.len = len; de.blk = model_block; de.err = (err_beat >= 0);
        done_q.push_back(de);
        end_expect++;
        dma_address = addr; dma_byte_enable = ie.be; dma_burst_size = 8'(n); launch_write = 1'b1;
        step();
        launch_write = 1'b0;
        launch_read  = stray_read;
        for (int i = 0; i < g; i++) begin
            step();
            launch_read = 1'b0;
        end
        bus_grant = 1'b1;
        step();
        bus_grant = 1'b0; launch_read = 1'b0;
        step();
        for (int k = 0; k < nb; k++) begin
            for (int s = 0; s < st[k]; s++) begin
                busy_in = 1'b1;
                step();
            end
            busy_in = 1'b0;
            step();
        end
        if (err_beat >= 0) begin
            bus_error_in = 1'b1;
            step();
            bus_error_in = 1'b0;
        end
        step(); step(); step();
    endtask

    // Read burst: slave returns nwords with random gaps, then ends; abort_after>=0 resets mid-burst.
    task automatic do_read(input logic [31:0] addr, input int n, input int g, input int nwords,
                           input int max_gap, input bit both, input int abort_after);
        int gap[300];
        logic [31:0] dat[300];
        int gend, len;
        init_t ie;
        done_t de;
        ramw_t rw;
        len = g + 2;
        for (int k = 0; k < nwords; k++) begin
            gap[k] = int'($urandom_range(0, max_gap));
            dat[k] = $urandom;
            len += gap[k] + 1;
            if (k < 256) begin
                rw.addr = 9'(k); rw.data = dat[k];
                ramw_q.push_back(rw);
            end
        end
        gend = int'($urandom_range(0, max_gap));
        len += gend + 1;
        model_block = (nwords > 255) ? 8'd255 : 8'(nwords);
        ie.addr = addr; ie.rnw = 1'b1; ie.be = 4'($urandom); ie.burst = 8'(n); ie.req_len = g + 1;
        init_q.push_back(ie);
        de.len = len; de.blk = model_block; de.err = 1'b0;
        done_q.push_back(de);
        dma_address = addr; dma_byte_enable = ie.be; dma_burst_size = 8'(n);
        launch_read = 1'b1; launch_write = both;
        step();
        launch_read = 1'b0; launch_write = 1'b0;
        for (int i = 0; i < g; i++) step();
        bus_grant = 1'b1;
        step();
        bus_grant = 1'b0;
        step();
        for (int k = 0; k < nwords; k++) begin
            if (k == abort_after) begin
                apply_reset();
                return;
            end
            for (int s = 0; s < gap[k]; s++) step();
            address_data_in = dat[k]; data_valid_in = 1'b1;
            step();
            data_valid_in = 1'b0;
        end
        for (int s = 0; s < gend; s++) step();
        end_transaction_in = 1'b1;
        step();
        end_transaction_in = 1'b0;
        step(); step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dma_address = 32'd0; dma_byte_enable = 4'd0; dma_burst_size = 8'd0; address_data_in = 32'd0;
        apply_reset();
        // Directed cases.
        do_write(32'h0000_1000, 3, 0, -1, 0, 1'b0, -1, 1'b0);
        do_write(32'h0000_2000, 3, 0, 1, 2, 1'b0, -1, 1'b0);
        do_read(32'h0000_3000, 4, 0, 5, 2, 1'b0, -1);
        do_read(32'h0000_4000, 255, 0, 258, 0, 1'b0, -1);
        do_write(32'h0000_5000, 5, 0, -1, 0, 1'b0, 2, 1'b0);
        @(negedge system_clk);
        chk("error_sticky", 128'(dma_error), 128'd1);
        step();
        do_read(32'h0000_7000, 2, 1, 3, 1, 1'b1, -1);
        do_read(32'h0000_8000, 9, 0, 10, 1, 1'b0, 4);
        do_write(32'h0000_6000, 4, 2, -1, 0, 1'b0, -1, 1'b1);
        // Randomised mix.
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write($urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), -1, 0, 1'b1, -1, 1'b0);
            else
                do_read($urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                        int'($urandom_range(1, 20)), 3, 1'b0, -1);
        end
        do_write(32'hFFFF_0000, 255, 1, -1, 0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("pending_init", 128'(init_q.size()), 128'd0);
        chk("pending_beats", 128'(beat_q.size()), 128'd0);
        chk("pending_bufwr", 128'(ramw_q.size()), 128'd0);
        chk("pending_done", 128'(done_q.size()), 128'd0);
        chk("pending_end", 128'(end_expect), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_dma_engine.md
# jtag_dma_engine

System-clock bus-master DMA sitting directly downstream of the JTAG chain-1 controller. It consumes the chain's launch pulses (after synchronisation), address, byte-enable and burst-size settings. It moves one burst between the DMA-side bank of the ping-pong buffer and the system bus. It reports completion through `DMA_busy` and the received word count through `DMA_block_size_IN`.

## Interface
Parameters:
- `ADDR_W`, 9: ping-pong buffer address width. Bit 8 is always driven 0 because the DMA bank uses entries 0..255.
- `BUF_WORDS`, 256: capacity of the DMA-side bank.

Ports:
- `system_clk` in 1: clock.
- `n_reset` in 1: reset, synchronous, active-low.
- `launch_write` in 1: single-cycle pulse (synchronised); transfers buffer data to the bus.
- `launch_read` in 1: single-cycle pulse (synchronised); transfers bus data to the buffer.
- `dma_address` in 32: start bus byte address; quasi-static, sampled on launch.
- `dma_byte_enable` in 4: byte enables; sampled on launch.
- `dma_burst_size` in 8: beats−1; sampled on launch.
- `dma_busy` out 1: high from the cycle after a launch until the engine returns to IDLE.
- `dma_block_size` out 8: words received by the last read, saturating at 255.
- `dma_error` out 1: sticky; set on bus error and cleared by the next launch.
- `pp_address` out 9: buffer address.
- `pp_write_enable` out 1: buffer write strobe.
- `pp_data_in` out 32: data written to the buffer.
- `pp_data_out` in 32: buffer read data, with 1-cycle synchronous read latency.
- `bus_request` out 1: bus request.
- `bus_grant` in 1: bus grant.
- `begin_transaction` out 1: start of a bus transaction.
- `address_data_out` out 32: address in the INIT cycle, write data in WRITE.
- `read_n_write` out 1: 1 = read transaction.
- `byte_enables` out 4: byte enables driven in INIT.
- `burst_size` out 8: burst size driven in INIT.
- `data_valid_out` out 1: write data valid.
- `end_transaction_out` out 1: end of a write transaction.
- `address_data_in` in 32: read data from the bus.
- `data_valid_in` in 1: read data valid.
- `end_transaction_in` in 1: slave ends the read burst.
- `busy_in` in 1: slave stall.
- `bus_error_in` in 1: bus error.

## Operation
- States: IDLE, REQUEST, INIT, WRITE, READ, END.
- IDLE:
  - On `launch_write` or `launch_read`: latch address, byte enables, burst size and direction; clear `dma_error` and the beat counter; go to REQUEST.
  - If both launches arrive in the same cycle, read wins.
  - Launches arriving outside IDLE are ignored.
- REQUEST:
  - `bus_request`=1 until `bus_grant`, then go to INIT.
  - In the grant cycle, `pp_address`=0 so that word 0 is available for a write.
- INIT (exactly 1 cycle):
  - `begin_transaction`=1.
  - `address_data_out`=latched address; `read_n_write`, `byte_enables` and `burst_size` are driven.
  - Next state is WRITE or READ.
- WRITE:
  - `data_valid_out`=1 and `address_data_out`=`pp_data_out`.
  - A beat is accepted when `busy_in`=0.
  - `pp_address` = beat_idx + accept, combinationally, so the RAM output always holds word[beat_idx].
  - After the beat with index burst_size is accepted, go to END.
- READ:
  - On `data_valid_in`: `pp_write_enable`=1, `pp_address`=beat_idx, `pp_data_in`=`address_data_in`, and beat_idx increments.
  - Writes are suppressed once beat_idx reaches BUF_WORDS (no wrap).
  - On `end_transaction_in`, go to IDLE and set `dma_block_size` = min(count, 255).
- END: `end_transaction_out`=1 for 1 cycle, then go to IDLE.
- `bus_error_in` in any non-IDLE state:
  - Set `dma_error` and go to END; if the state was REQUEST, go straight to IDLE instead.
  - `dma_block_size` is left unchanged.
- Arithmetic:
  - beat_idx is 9 bits.
  - Beats = burst_size+1 (range 1..256).
  - The write index is compared against the 8-bit burst size zero-extended.

## Timing
- Reset: all outputs 0; state IDLE; `dma_block_size`=0; `dma_error`=0.
- Reset has priority in every state, including an in-flight burst.
- `dma_busy` rises the cycle after the launch pulse and falls the cycle IDLE is re-entered.
- Minimum write of N beats, grant immediate: launch→REQUEST 1, INIT 1, WRITE N, END 1.
  - `dma_busy` is high for N+3 cycles.
- Write throughput is 1 beat/cycle with no bubbles while `busy_in`=0.
- A stall holds `address_data_out` and `pp_address` stable.
- `dma_block_size` updates in the same cycle the engine leaves READ.

## Structure
- A shared package holds:
  - the state encoding constants;
  - `BUF_WORDS`;
  - bus field widths (32/4/8).
- Natural sub-module: `dma_bus_master_if`, which handles the request/grant/INIT sequencing and is reusable by other masters.
- The datapath and FSM stay in `jtag_dma_engine`.

## Test plan
- Write, burst_size=3, addr 0x1000, buffer words 0..3 = A0..A3, grant immediate, no stalls:
  - INIT shows 0x1000 with `read_n_write`=0.
  - Four beats A0..A3 on consecutive cycles, then `end_transaction_out`.
  - `dma_busy` high for 7 cycles.
- Write burst_size=3 with `busy_in` high during the beat-1 cycle and the one after:
  - A1 is held for 3 cycles and none is duplicated or skipped.
  - `pp_address` is stable across the stall.
- Read, burst_size=4, slave returns 5 words with gaps, then `end_transaction_in`:
  - Buffer 0..4 hold the words.
  - `dma_block_size`=5 and `dma_busy` falls.
- Read where the slave sends 256 words:
  - Buffer 0..255 are written with no write to the 257th address.
  - `dma_block_size`=255.
- `bus_error_in` during WRITE beat 2:
  - `end_transaction_out` pulses.
  - `dma_error`=1 until the next launch.
  - `dma_block_size` is unchanged.
- Reset mid-READ, then a `launch_write` pulse with `launch_read` arriving during REQUEST:
  - All outputs are 0 after reset.
  - The write proceeds and the stray read is ignored.
